// File: rtl/pp_pipeline_accel_entry_proc_bcast.sv
// rtl/pp_pipeline_accel_entry_proc_bcast.sv - scalar argument broadcaster into per-channel FIFOs
module pp_pipeline_accel_entry_proc_bcast #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 64
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic                     ap_start,
   output logic                     ap_ready,
   output logic                     ap_done,
   input  logic                     ap_continue,
   output logic                     ap_idle,
   input  logic [NUM_CH*DATA_W-1:0] args_in,
   output logic [NUM_CH*DATA_W-1:0] ch_din,
   input  logic [NUM_CH-1:0]        ch_full_n,
   output logic [NUM_CH-1:0]        ch_write,
   output logic [NUM_CH-1:0]        pending
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]               state;
   logic [NUM_CH*DATA_W-1:0] arg_reg;
   logic [NUM_CH-1:0]        pend_reg;
   logic [NUM_CH-1:0]        left_after;

   // Handshake outputs: writes only in XFER, each channel gated by its own full_n
   always_comb begin
      ap_ready   = (state == S_IDLE) & ap_start;
      ap_idle    = (state == S_IDLE) & ~ap_start;
      ap_done    = (state == S_DONE);
      ch_write   = (state == S_XFER) ? (pend_reg & ch_full_n) : '0;
      left_after = pend_reg & ~ch_write;
      ch_din     = arg_reg;
      pending    = pend_reg;
   end

   // Control FSM: capture on start, retire channels as they write, hold done until continue
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state    <= S_IDLE;
         arg_reg  <= '0;
         pend_reg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  arg_reg  <= args_in;
                  pend_reg <= '1;
                  state    <= S_XFER;
               end
            end
            S_XFER: begin
               pend_reg <= left_after;
               if (left_after == '0) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (ap_continue) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state    <= S_IDLE;
               pend_reg <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pp_pipeline_accel_entry_proc_bcast.sv
// tb/tb_pp_pipeline_accel_entry_proc_bcast.sv - directed and randomized checks of the argument broadcaster
module tb_pp_pipeline_accel_entry_proc_bcast;

   logic         ap_clk;
   logic         ap_rst;
   logic         ap_start;
   logic         ap_ready;
   logic         ap_done;
   logic         ap_continue;
   logic         ap_idle;
   logic [255:0] args_in;
   logic [255:0] ch_din;
   logic [3:0]   ch_full_n;
   logic [3:0]   ch_write;
   logic [3:0]   pending;

   int n_tests = 0;
   int n_fail  = 0;

   pp_pipeline_accel_entry_proc_bcast #(.NUM_CH(4), .DATA_W(64)) dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .ap_start    (ap_start),
      .ap_ready    (ap_ready),
      .ap_done     (ap_done),
      .ap_continue (ap_continue),
      .ap_idle     (ap_idle),
      .args_in     (args_in),
      .ch_din      (ch_din),
      .ch_full_n   (ch_full_n),
      .ch_write    (ch_write),
      .pending     (pending)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge ap_clk);
      #2;
   endtask

   logic [255:0] a_args, b_args, c_args, d_args, e_args, cap;
   int ready_cnt, done_cnt, viol, timeouts;
   int wcnt [4];
   bit finished;

   initial begin
      a_args = {64'h438, 64'h780, 64'h2000, 64'h1000};
      b_args = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
      c_args = {64'hC3C3, 64'hC2C2, 64'hC1C1, 64'hC0C0};
      d_args = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      e_args = {64'hE3, 64'hE2, 64'hE1, 64'hE0};

      ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
      ch_full_n = 4'hF; args_in = '0;
      next_cycle();
      next_cycle();
      ap_rst = 1'b0;
      #1;
      chk("rst_idle", ap_idle, 1);
      chk("rst_done", ap_done, 0);
      chk("rst_ready", ap_ready, 0);
      chk("rst_write", ch_write, 0);
      chk("rst_din", ch_din, 0);
      chk("rst_pending", pending, 0);

      // minimum latency run
      args_in = a_args; ap_start = 1'b1; ap_continue = 1'b1; #1;
      chk("t1_c0_ready", ap_ready, 1);
      chk("t1_c0_idle", ap_idle, 0);
      next_cycle(); ap_start = 1'b0; #1;
      chk("t1_c1_write", ch_write, 4'hF);
      chk("t1_c1_din", ch_din, a_args);
      chk("t1_c1_ready", ap_ready, 0);
      next_cycle(); #1;
      chk("t1_c2_done", ap_done, 1);
      chk("t1_c2_write", ch_write, 0);
      next_cycle(); #1;
      chk("t1_c3_idle", ap_idle, 1);
      chk("t1_c3_done", ap_done, 0);

      // channel 2 blocked for cycles 1..5, continue held low afterwards
      args_in = b_args; ap_start = 1'b1; ap_continue = 1'b0; ch_full_n = 4'b1011; #1;
      chk("t2_c0_ready", ap_ready, 1);
      next_cycle(); ap_start = 1'b0; #1;
      chk("t2_c1_write", ch_write, 4'b1011);
      for (int c = 2; c <= 5; c++) begin
         next_cycle(); #1;
         chk($sformatf("t2_c%0d_write", c), ch_write, 0);
         chk($sformatf("t2_c%0d_pending", c), pending, 4'b0100);
         chk($sformatf("t2_c%0d_done", c), ap_done, 0);
      end
      next_cycle(); ch_full_n = 4'hF; #1;
      chk("t2_c6_write", ch_write, 4'b0100);
      chk("t2_c6_din", ch_din, b_args);
      next_cycle(); #1;
      chk("t2_c7_done", ap_done, 1);
      chk("t2_c7_pending", pending, 0);

      // done held while continue low; start ignored
      args_in = c_args;
      for (int c = 0; c < 10; c++) begin
         next_cycle(); ap_start = 1'b1; #1;
         chk($sformatf("t3_hold%0d_done", c), ap_done, 1);
         chk($sformatf("t3_hold%0d_ready", c), ap_ready, 0);
      end
      next_cycle(); ap_continue = 1'b1; #1;
      chk("t3_rel_done", ap_done, 1);
      chk("t3_rel_ready", ap_ready, 0);
      next_cycle(); #1;
      chk("t3_accept_ready", ap_ready, 1);
      chk("t3_accept_done", ap_done, 0);

      // args changing during a stretched XFER
      next_cycle(); ap_start = 1'b0; ch_full_n = 4'b1110;
      for (int c = 0; c < 3; c++) begin
         args_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         #1;
         chk($sformatf("t4_c%0d_din", c), ch_din, c_args);
         next_cycle();
      end
      ch_full_n = 4'hF; #1;
      chk("t4_last_write", ch_write, 4'b0001);
      next_cycle(); #1;
      chk("t4_done", ap_done, 1);
      next_cycle(); #1;
      chk("t4_idle", ap_idle, 1);

      // reset mid-XFER with channel 1 blocked
      args_in = d_args; ap_start = 1'b1; ch_full_n = 4'b1101; #1;
      chk("t5_c0_ready", ap_ready, 1);
      next_cycle(); ap_start = 1'b0; #1;
      chk("t5_c1_write", ch_write, 4'b1101);
      next_cycle(); #1;
      chk("t5_c2_pending", pending, 4'b0010);
      next_cycle(); ap_rst = 1'b1; #1;
      next_cycle(); ap_rst = 1'b0; #1;
      chk("t5_c4_idle", ap_idle, 1);
      chk("t5_c4_done", ap_done, 0);
      chk("t5_c4_ready", ap_ready, 0);
      chk("t5_c4_write", ch_write, 0);
      chk("t5_c4_din", ch_din, 0);
      chk("t5_c4_pending", pending, 0);
      next_cycle(); args_in = e_args; ap_start = 1'b1; ch_full_n = 4'hF; #1;
      chk("t5_c5_ready", ap_ready, 1);
      next_cycle(); ap_start = 1'b0; #1;
      chk("t5_c6_write", ch_write, 4'hF);
      chk("t5_c6_din", ch_din, e_args);
      next_cycle(); #1;
      chk("t5_c7_done", ap_done, 1);
      next_cycle(); #1;

      // randomized scoreboard
      ready_cnt = 0; done_cnt = 0; viol = 0; timeouts = 0;
      for (int r = 0; r < 1000; r++) begin
         args_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         cap = args_in;
         ap_start = 1'b1;
         ap_continue = 1'($urandom_range(0, 1));
         ch_full_n = 4'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < 4; i++) wcnt[i] = 0;
         if (ap_ready) ready_cnt++; else viol++;
         if (ch_write != 0) viol++;
         next_cycle();
         finished = 1'b0;
         for (int c = 0; c < 100 && !finished; c++) begin
            ap_start = 1'($urandom_range(0, 1));
            ap_continue = 1'($urandom_range(0, 1));
            ch_full_n = 4'($urandom_range(0, 15));
            args_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            if (ap_ready) ready_cnt++;
            if ((ch_write & ~ch_full_n) != 0) viol++;
            if (ch_din !== cap) viol++;
            for (int i = 0; i < 4; i++) if (ch_write[i]) wcnt[i]++;
            if (ap_done && ap_continue) begin
               done_cnt++;
               finished = 1'b1;
            end
            next_cycle();
         end
         if (!finished) timeouts++;
         for (int i = 0; i < 4; i++) if (wcnt[i] != 1) viol++;
         if (!finished) begin
            ap_rst = 1'b1; next_cycle(); ap_rst = 1'b0;
         end
      end
      ap_start = 1'b0;
      chk("rand_violations", viol, 0);
      chk("rand_timeouts", timeouts, 0);
      chk("rand_ready_eq_done", ready_cnt, done_cnt);
      chk("rand_done_count", done_cnt, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pp_pipeline_accel_entry_proc_bcast.md
# pp_pipeline_accel_entry_proc_bcast

Parametrised scalar-argument broadcaster for the pp_pipeline_accel dataflow region. On each ap_ctrl_chain start it captures NUM_CH scalar kernel arguments (buffer addresses, line strides, dimensions) and writes each one once into its own downstream channel FIFO. Each channel handshakes independently, so a stalled consumer does not block the others. ap_done is raised only after every channel has been written. It is the next generation of the two-argument entry process and replaces per-kernel hand-written copies.

## Interface
Parameters:
- NUM_CH, 4, number of scalar arguments/channel FIFOs (1..16)
- DATA_W, 64, width of each argument; narrower arguments are zero-extended by the instantiator

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  start request (ap_ctrl_chain)
- ap_ready  out  1  one-cycle pulse: arguments captured, next start may be presented
- ap_done  out  1  all channels written; held until ap_continue
- ap_continue  in  1  releases ap_done
- ap_idle  out  1  high in IDLE while ap_start is low
- args_in  in  NUM_CH*DATA_W  packed arguments; channel i = bits [i*DATA_W +: DATA_W]
- ch_din  out  NUM_CH*DATA_W  packed FIFO data, same packing
- ch_full_n  in  NUM_CH  per-channel FIFO not-full
- ch_write  out  NUM_CH  per-channel FIFO write strobe
- pending  out  NUM_CH  debug: bit i high while channel i is still unwritten in the current run

## Operation
- The FSM has three states: IDLE, XFER and DONE. Reset enters IDLE.
- IDLE:
  - If ap_start=1: capture args_in into arg_reg, set pending to all-ones, pulse ap_ready=1 for this cycle, and go to XFER.
  - Otherwise hold.
- XFER:
  - ch_write[i] = pending[i] & ch_full_n[i]. This is combinational.
  - On a write, clear pending[i] at the clock edge.
  - When pending & ~ch_write is zero this cycle (all channels done or finishing now), go to DONE at the next edge.
  - ap_start is ignored in XFER; ap_ready stays 0.
- DONE:
  - ap_done=1 (registered, from state).
  - If ap_continue=1, go to IDLE at the next edge. Otherwise hold, with ap_done high.
  - ap_start is ignored until IDLE is reached.
- ch_din always equals arg_reg. It is stable from the cycle after capture until the next capture.
- Each channel is written exactly once per run, and never while its ch_full_n=0.
- ap_idle = (state==IDLE) & ~ap_start.

## Timing
- Reset values:
  - state=IDLE, arg_reg=0, pending=0.
  - ap_done=0, ap_ready=0, ch_write=0, ch_din=0.
  - ap_idle=1 if ap_start=0.
- Minimum latency, with all FIFOs non-full:
  - Start accepted in cycle 0 (ap_ready=1).
  - All ch_write=1 in cycle 1.
  - ap_done=1 from cycle 2.
- Back-to-back runs, with ap_continue held high:
  - ap_done is high for exactly one cycle (cycle 2).
  - IDLE is reached at cycle 3, and the next start can be accepted in cycle 3.
  - Sustained throughput is therefore one run per 3 cycles.
- A channel blocked for k cycles delays ap_done by k cycles. Other channels write in cycle 1 regardless.
- ch_full_n may toggle every cycle. A write occurs in any XFER cycle where both pending[i] and ch_full_n[i] are high.
- If ap_continue is already high on entry to DONE, ap_done still pulses for one cycle.
- ap_rst asserted mid-XFER or mid-DONE:
  - Next cycle is IDLE with all outputs at their reset values.
  - Partially written channels are not replayed. Downstream FIFOs are reset by the same ap_rst.
- Changes on args_in after the capture cycle have no effect on ch_din.

## Test plan
- NUM_CH=4, DATA_W=64, all full_n=1, args {0x1000, 0x2000, 0x780, 0x438}, start pulse:
  - ap_ready in cycle 0.
  - ch_write=4'b1111 with matching ch_din in cycle 1.
  - ap_done in cycle 2; IDLE in cycle 3 with ap_continue=1.
- Channel 2 full_n=0 for 5 cycles:
  - Channels 0, 1 and 3 write in cycle 1.
  - ch_write[2] rises in cycle 6.
  - pending goes 4'b0100 to 0; ap_done in cycle 7.
- ap_continue held low for 10 cycles after done:
  - ap_done stays high.
  - ap_start=1 during that time produces no ap_ready.
  - After ap_continue=1, the next start is accepted one cycle later.
- args_in changed every cycle during XFER: ch_din still equals the values captured in cycle 0.
- ap_rst asserted in cycle 3 while channel 1 is blocked:
  - All outputs are at reset values in cycle 4.
  - A new start in cycle 5 is accepted with the new args.
- Scoreboard over 1000 random runs with random full_n and ap_continue:
  - Exactly NUM_CH writes per run, one per channel.
  - No write while full_n=0.
  - ap_ready count equals ap_done count.
